// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer input path.
package timer_pkg;

  localparam int CLK_HZ_DEF        = 50_000_000;
  localparam int DEBOUNCE_MS_DEF   = 20;
  localparam int LONG_PRESS_MS_DEF = 1000;

  typedef enum logic [1:0] {
    SUPPRESS = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    LONG     = 2'd3
  } key_state_t;

  // Milliseconds to clock cycles; divide first so 50 MHz * 1000 ms stays in 32 bits.
  function automatic int ms_to_cnt(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability counter: the output follows the
// synchronised input only after it has differed from the output for CNT cycles.
module debounce_sync #(
  parameter int   CNT     = 20,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CNT + 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Metastability guard on the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  // Count consecutive mismatch cycles; any return to the stable value restarts.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CW'(CNT - 1)) begin
        stable_d = s2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/key_event_conditioner.sv
// Turns raw KEY1 / SW0 into clean events for the timer core: short press toggles
// run/pause, long press clears, switch change pulses ModeChanged and stops the core.
module key_event_conditioner
  import timer_pkg::*;
#(
  parameter int CLK_HZ        = CLK_HZ_DEF,
  parameter int DEBOUNCE_MS   = DEBOUNCE_MS_DEF,
  parameter int LONG_PRESS_MS = LONG_PRESS_MS_DEF
) (
  input  logic CLK_50MHz,
  input  logic rst_n,
  input  logic KeyStartStop_n,
  input  logic SwModeSel,
  output logic StartStopPulse,
  output logic ClearPulse,
  output logic Running,
  output logic ModeSel,
  output logic ModeChanged
);

  localparam int DB_CNT = ms_to_cnt(CLK_HZ, DEBOUNCE_MS);
  localparam int LP_CNT = ms_to_cnt(CLK_HZ, LONG_PRESS_MS);
  localparam int HW     = $clog2(LP_CNT + 1);
  localparam int NUM_IN = 2;
  localparam int KEY    = 0;
  localparam int SW     = 1;

  logic [NUM_IN-1:0] raw, db;

  assign raw = {SwModeSel, KeyStartStop_n};

  // Both inputs reset to 0: the key reads as pressed until proven released,
  // which is what lets SUPPRESS swallow a key held through reset.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    debounce_sync #(
      .CNT     (DB_CNT),
      .RST_VAL (1'b0)
    ) u_db (
      .clk   (CLK_50MHz),
      .rst_n (rst_n),
      .din   (raw[g]),
      .dout  (db[g])
    );
  end

  logic key_rel;
  logic mode_edge;

  assign key_rel = db[KEY];

  key_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          run_q, run_d;
  logic          ss_q, ss_d;
  logic          clr_q, clr_d;
  logic          msel_q, msel_d;
  logic          mchg_q, mchg_d;

  assign mode_edge = db[SW] ^ msel_q;

  // Key FSM, hold counter, run flag and mode edge; a mode change overrides
  // any key event landing in the same cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    run_d   = run_q;
    ss_d    = 1'b0;
    clr_d   = 1'b0;
    msel_d  = db[SW];
    mchg_d  = mode_edge;

    case (state_q)
      SUPPRESS: if (key_rel) state_d = IDLE;
      IDLE: begin
        if (!key_rel) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (hold_q == HW'(LP_CNT - 1)) begin
          clr_d   = 1'b1;
          run_d   = 1'b0;
          state_d = LONG;
        end else if (key_rel) begin
          ss_d    = 1'b1;
          run_d   = ~run_q;
          state_d = IDLE;
        end else if (hold_q != HW'(LP_CNT)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG:     if (key_rel) state_d = IDLE;
      default:  state_d = SUPPRESS;
    endcase

    if (mode_edge) begin
      ss_d  = 1'b0;
      clr_d = 1'b0;
      run_d = 1'b0;
      if (state_q == PRESSED || state_q == LONG) state_d = SUPPRESS;
    end
  end

  // Registered state and outputs.
  always_ff @(posedge CLK_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SUPPRESS;
      hold_q  <= '0;
      run_q   <= 1'b0;
      ss_q    <= 1'b0;
      clr_q   <= 1'b0;
      msel_q  <= 1'b0;
      mchg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
      ss_q    <= ss_d;
      clr_q   <= clr_d;
      msel_q  <= msel_d;
      mchg_q  <= mchg_d;
    end
  end

  assign StartStopPulse = ss_q;
  assign ClearPulse     = clr_q;
  assign Running        = run_q;
  assign ModeSel        = msel_q;
  assign ModeChanged    = mchg_q;

endmodule

// File: tb/tb_key_event_conditioner.sv
// Bench for key_event_conditioner at CLK_HZ=1000 (DB_CNT=20, LP_CNT=1000).
module tb_key_event_conditioner;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst_n, key_n, sw;
  logic ss, clr, running, msel, mchg;

  always #10 clk = ~clk;

  key_event_conditioner #(
    .CLK_HZ        (1000),
    .DEBOUNCE_MS   (20),
    .LONG_PRESS_MS (1000)
  ) dut (
    .CLK_50MHz      (clk),
    .rst_n          (rst_n),
    .KeyStartStop_n (key_n),
    .SwModeSel      (sw),
    .StartStopPulse (ss),
    .ClearPulse     (clr),
    .Running        (running),
    .ModeSel        (msel),
    .ModeChanged    (mchg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: event vector {ModeChanged, ClearPulse, StartStopPulse} and Running after it.
  typedef struct packed {
    logic [2:0] ev;
    logic       run;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int         hold;
    bit         bounce;
    logic [2:0] ev;
    logic       run;
  } vec_t;
  vec_t vecs[7];

  localparam logic [2:0] EV_SS  = 3'b001;
  localparam logic [2:0] EV_CLR = 3'b010;
  localparam logic [2:0] EV_MC  = 3'b100;

  logic [2:0] mon_ev;
  logic [2:0] prev_ev = 3'b000;
  exp_t       mon_e;

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    mon_ev = {mchg, clr, ss};
    if (rst_n && mon_ev != 3'b000) begin
      if (prev_ev != 3'b000) chk("pulse_width", 32'(prev_ev & mon_ev), 32'd0);
      chk("ss_clr_excl", 32'(ss & clr), 32'd0);
      if (sb_q.size() == 0) chk("unexpected_event", 32'(mon_ev), 32'd0);
      else begin
        mon_e = sb_q.pop_front();
        chk("event_kind", 32'(mon_ev), 32'(mon_e.ev));
        chk("event_running", 32'(running), 32'(mon_e.run));
      end
    end
    prev_ev = mon_ev;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input bit bounce);
    if (bounce) for (int i = 0; i < 12; i++) begin key_n = ~key_n; cyc(5); end
    key_n = 1'b0;
    cyc(hold);
    if (bounce) for (int i = 0; i < 12; i++) begin key_n = ~key_n; cyc(5); end
    key_n = 1'b1;
    cyc(60);
  endtask

  task automatic chk_state(input string name, input key_state_t s);
    chk(name, 32'(dut.state_q), 32'(s));
  endtask

  initial begin
    vecs[0] = '{hold: 200,  bounce: 1'b1, ev: EV_SS,  run: 1'b1};
    vecs[1] = '{hold: 200,  bounce: 1'b1, ev: EV_SS,  run: 1'b0};
    vecs[2] = '{hold: 1100, bounce: 1'b0, ev: EV_CLR, run: 1'b0};
    vecs[3] = '{hold: 100,  bounce: 1'b0, ev: EV_SS,  run: 1'b1};
    vecs[4] = '{hold: 1100, bounce: 1'b1, ev: EV_CLR, run: 1'b0};
    vecs[5] = '{hold: 30,   bounce: 1'b0, ev: EV_SS,  run: 1'b1};
    vecs[6] = '{hold: 10,   bounce: 1'b0, ev: 3'b000, run: 1'b1};

    // Reset with key released, switch low.
    rst_n = 1'b0; key_n = 1'b1; sw = 1'b0;
    cyc(3);
    chk("rst_ss", 32'(ss), 32'd0);
    chk("rst_clr", 32'(clr), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_modesel", 32'(msel), 32'd0);
    chk("rst_modechg", 32'(mchg), 32'd0);
    rst_n = 1'b1;
    cyc(10);
    chk_state("state_suppress_after_rst", SUPPRESS);
    cyc(20);
    chk_state("state_idle_after_rst", IDLE);

    // Presses: bounce, long, short, glitch.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ev != 3'b000) sb_q.push_back('{ev: vecs[i].ev, run: vecs[i].run});
      press(vecs[i].hold, vecs[i].bounce);
      chk($sformatf("vec%0d_drain", i), 32'(sb_q.size()), 32'd0);
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].run));
      chk_state($sformatf("vec%0d_state", i), IDLE);
    end

    // Mode change while running, then a short switch glitch.
    sb_q.push_back('{ev: EV_MC, run: 1'b0});
    sw = 1'b1;
    cyc(30);
    chk("mode_modesel", 32'(msel), 32'd1);
    chk("mode_drain", 32'(sb_q.size()), 32'd0);
    chk("mode_running", 32'(running), 32'd0);
    sw = 1'b0;
    cyc(10);
    sw = 1'b1;
    cyc(40);
    chk("glitch_modesel", 32'(msel), 32'd1);

    // Collision: key release and switch edge debounce on the same cycle.
    sb_q.push_back('{ev: EV_SS, run: 1'b1});
    press(100, 1'b0);
    chk("pre_coll_running", 32'(running), 32'd1);
    sb_q.push_back('{ev: EV_MC, run: 1'b0});
    key_n = 1'b0;
    cyc(100);
    key_n = 1'b1;
    sw    = 1'b0;
    cyc(60);
    chk("coll_drain", 32'(sb_q.size()), 32'd0);
    chk("coll_running", 32'(running), 32'd0);
    chk("coll_modesel", 32'(msel), 32'd0);
    chk_state("coll_state", IDLE);

    // Reset while the key is held: press is discarded.
    key_n = 1'b0;
    cyc(100);
    chk_state("midpress_state", PRESSED);
    rst_n = 1'b0;
    cyc(3);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_ss", 32'(ss), 32'd0);
    chk_state("midrst_state", SUPPRESS);
    rst_n = 1'b1;
    cyc(50);
    chk_state("held_state", SUPPRESS);
    key_n = 1'b1;
    cyc(60);
    chk("midrst_drain", 32'(sb_q.size()), 32'd0);
    chk_state("midrst_final_state", IDLE);
    chk("midrst_final_running", 32'(running), 32'd0);

    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
